anton_neopixel_stream_sequencer: RTL and testbench
==================================================

Name: anton_neopixel_stream_sequencer

Overview:
Parametrised successor of the NeoPixel stream timing logic. It generates the sub-bit, bit and pixel counters that drive the serial pattern generator and buffer read address. It adds a configurable pattern length, RGB (24-bit) or RGBW (32-bit) pixels, a programmable start pixel, one-shot or loop framing, graceful stop, a frame-done pulse and a frame counter. It sits between the APB register block and the pattern/output stage in the 6.4 MHz domain.

Parameters:
BUFFER_END, `BUFFER_END_DEFAULT, last valid byte index of the pixel buffer
RESET_DELAY, `RESET_DELAY_DEFAULT, latch (reset) low-time in clk6_4mhz ticks minus 1
PATTERN_STEPS, 8, sub-bit steps per NeoPixel bit (power of 2, 2..16)
FRAME_CNT_BITS, 16, width of the frame counter
localparam BUFFER_BITS, `CLOG2(BUFFER_END+1), pixel index width
localparam STEP_BITS, `CLOG2(PATTERN_STEPS), sub-bit index width

Ports:
clk6_4mhz  in  1  stream clock
rstn  in  1  asynchronous active-low reset
regCtrlInit  in  1  synchronous init; forces IDLE
regCtrlRun  in  1  run enable (level)
regCtrlLoop  in  1  1 = restart after latch, 0 = one-shot
regCtrlLimit  in  1  1 = use regMax, 0 = use BUFFER_END
regCtrl32bit  in  1  pixels on 4-byte stride
regCtrlRgbw  in  1  1 = 32 bits/pixel, 0 = 24
regMin  in  13  first pixel index
regMax  in  13  last pixel index when limit enabled
initSlow  in  1  slow-domain init request
initSlowDone  out  1  one-cycle ack of initSlow
bitPatternIndex  out  STEP_BITS  sub-bit step
pixelBitIndex  out  5  bit within pixel (0..23 or 0..31)
pixelIndex  out  BUFFER_BITS  current buffer index
pixelIndexMax  out  BUFFER_BITS  effective last index
state  out  2  0 IDLE, 1 TRANSMIT, 2 LATCH, 3 HALT
streamOutput  out  1  high in TRANSMIT
streamReset  out  1  high in LATCH
streamBitOf  out  1  last step of last bit of a pixel
streamPixelOf  out  1  streamBitOf on last pixel
streamSyncOf  out  1  last LATCH cycle
frameDone  out  1  one-cycle pulse at frame end
frameCount  out  FRAME_CNT_BITS  completed frames, wraps

Behaviour:
- rstn low: all registers 0, state IDLE, all outputs 0; pixelIndexMax stays combinational.
- pixelIndexMax = regCtrlLimit ? regMax[BUFFER_BITS-1:0] : BUFFER_END.
- Start index = regMin truncated to BUFFER_BITS; low 2 bits cleared when regCtrl32bit.
- Equivalent index = regCtrl32bit ? {pixelIndex[BUFFER_BITS-1:2],2'b11} : pixelIndex. Last pixel when equiv >= pixelIndexMax (so regMin > max sends exactly one pixel).
- IDLE: when regCtrlRun && !regCtrlInit, next cycle enter TRANSMIT with pixelIndex = start, bit/step = 0. Latch regCtrlRgbw into bpp (24/32); bpp is held for the whole frame.
- TRANSMIT: bitPatternIndex increments every cycle. At PATTERN_STEPS-1, pixelBitIndex increments; at bpp-1 it returns to 0 (streamBitOf). At streamBitOf, pixelIndex advances by 4 (32-bit mode) or 1, or returns to start on the last pixel.
- streamPixelOf -> LATCH. If regCtrlRun drops mid-frame, set stopPending; at the next streamBitOf go to LATCH. The current pixel is never truncated.
- LATCH: resetDelayCount increments every cycle; streamSyncOf when it equals RESET_DELAY. LATCH therefore lasts RESET_DELAY+1 cycles. On streamSyncOf: count=0, frameDone=1 for that cycle, frameCount+1.
  - Then TRANSMIT if regCtrlLoop && regCtrlRun && !stopPending.
  - Else HALT if regCtrlRun is still high.
  - Else IDLE. stopPending is cleared.
- HALT: waits for regCtrlRun = 0, then IDLE. A one-shot needs a run deassert/reassert to repeat.
- regCtrlInit high: next cycle state IDLE; counters, stopPending and resetDelayCount cleared; frameCount kept. Init takes priority over every transition.
- initSlow high: pixel/bit/step counters cleared; initSlowDone high the next cycle for exactly one cycle, even if initSlow stays high (re-arms after initSlow low).
- Counters wrap only as stated; index arithmetic is modulo 2^BUFFER_BITS.

Test Plan:
- BUFFER_END=3, RESET_DELAY=10, 8-bit RGB, loop=0, run=1 -> 768 TRANSMIT cycles, pixelIndex 0,1,2,3; 11 LATCH cycles; frameDone pulse; frameCount=1; state HALT until run=0, then IDLE.
- Same with loop=1 for 3 frames -> frameCount=3, TRANSMIT restarts at index 0 the cycle after each streamSyncOf, no IDLE cycle.
- BUFFER_END=15, 32bit=1, rgbw=1, regMin=5 -> indices 4,8,12; pixelBitIndex reaches 31; frame = 3*32*8 = 768 cycles.
- Run dropped at pixel 1 bit 10 -> pixel 1 completes (streamBitOf), then LATCH, then IDLE; pixel 2 never sent.
- regCtrlInit asserted mid-LATCH -> IDLE next cycle, resetDelayCount=0, frameCount unchanged; rstn pulse mid-TRANSMIT -> all outputs 0 immediately.
- initSlow held 5 cycles -> initSlowDone high exactly 1 cycle; limit=1, regMax=2, regMin=3 -> exactly one pixel (index 3) sent.

Source files
------------

// File: rtl/anton_neopixel_stream_sequencer.sv
// ============================================================================
// Module   : anton_neopixel_stream_sequencer
// Purpose  : Step/bit/pixel sequencing and latch timing for the NeoPixel stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 1023
`endif
`ifndef RESET_DELAY_DEFAULT
`define RESET_DELAY_DEFAULT 383
`endif

module anton_neopixel_stream_sequencer #(
    parameter int  BUFFER_END     = `BUFFER_END_DEFAULT,
    parameter int  RESET_DELAY    = `RESET_DELAY_DEFAULT,
    parameter int  PATTERN_STEPS  = 8,
    parameter int  FRAME_CNT_BITS = 16,
    localparam int BUFFER_BITS    = $clog2(BUFFER_END + 1),
    localparam int STEP_BITS      = $clog2(PATTERN_STEPS)
) (
    input  logic                      clk6_4mhz,
    input  logic                      rstn,
    input  logic                      regCtrlInit,
    input  logic                      regCtrlRun,
    input  logic                      regCtrlLoop,
    input  logic                      regCtrlLimit,
    input  logic                      regCtrl32bit,
    input  logic                      regCtrlRgbw,
    input  logic [12:0]               regMin,
    input  logic [12:0]               regMax,
    input  logic                      initSlow,
    output logic                      initSlowDone,
    output logic [STEP_BITS-1:0]      bitPatternIndex,
    output logic [4:0]                pixelBitIndex,
    output logic [BUFFER_BITS-1:0]    pixelIndex,
    output logic [BUFFER_BITS-1:0]    pixelIndexMax,
    output logic [1:0]                state,
    output logic                      streamOutput,
    output logic                      streamReset,
    output logic                      streamBitOf,
    output logic                      streamPixelOf,
    output logic                      streamSyncOf,
    output logic                      frameDone,
    output logic [FRAME_CNT_BITS-1:0] frameCount
);

    localparam int DELAY_BITS = (RESET_DELAY < 1) ? 1 : $clog2(RESET_DELAY + 1);
    localparam logic [DELAY_BITS-1:0] DELAY_LAST = DELAY_BITS'(RESET_DELAY);
    localparam logic [STEP_BITS-1:0]  STEP_LAST  = STEP_BITS'(PATTERN_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRANSMIT = 2'd1,
        ST_LATCH    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t                    cur_state, nxt_state;
    logic [STEP_BITS-1:0]      step_q, step_d;
    logic [4:0]                bit_q, bit_d;
    logic [BUFFER_BITS-1:0]    pix_q, pix_d;
    logic                      bpp32_q, bpp32_d;
    logic                      stop_q, stop_d;
    logic [DELAY_BITS-1:0]     delay_q, delay_d;
    logic [FRAME_CNT_BITS-1:0] frame_cnt_q, frame_cnt_d;
    logic                      slow_seen_q, slow_done_q;

    logic [BUFFER_BITS-1:0]    start_idx, equiv_idx, stride;
    logic                      step_last, bit_last, last_pixel;
    logic                      bit_of, sync_of;
    logic                      unused_hi;

    assign unused_hi = ^{regMin[12:BUFFER_BITS], regMax[12:BUFFER_BITS]};

    assign pixelIndexMax = regCtrlLimit ? regMax[BUFFER_BITS-1:0] : BUFFER_BITS'(BUFFER_END);
    assign start_idx     = regCtrl32bit ? (regMin[BUFFER_BITS-1:0] & ~BUFFER_BITS'(3))
                                        : regMin[BUFFER_BITS-1:0];
    // In 32-bit stride mode a pixel owns the whole 4-byte slot, so compare its top byte.
    assign equiv_idx     = regCtrl32bit ? (pix_q | BUFFER_BITS'(3)) : pix_q;
    assign stride        = regCtrl32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1);
    assign last_pixel    = (equiv_idx >= pixelIndexMax);

    assign step_last = (step_q == STEP_LAST);
    assign bit_last  = (bit_q == (bpp32_q ? 5'd31 : 5'd23));
    assign bit_of    = (cur_state == ST_TRANSMIT) && step_last && bit_last;
    assign sync_of   = (cur_state == ST_LATCH) && (delay_q == DELAY_LAST);

    always_comb begin
        nxt_state   = cur_state;
        step_d      = step_q;
        bit_d       = bit_q;
        pix_d       = pix_q;
        bpp32_d     = bpp32_q;
        stop_d      = stop_q;
        delay_d     = delay_q;
        frame_cnt_d = frame_cnt_q;

        case (cur_state)
            ST_IDLE: begin
                if (regCtrlRun) begin
                    nxt_state = ST_TRANSMIT;
                    step_d    = '0;
                    bit_d     = '0;
                    pix_d     = start_idx;
                    bpp32_d   = regCtrlRgbw;
                    stop_d    = 1'b0;
                end
            end
            ST_TRANSMIT: begin
                step_d = step_q + STEP_BITS'(1);
                if (!regCtrlRun) begin
                    stop_d = 1'b1;
                end
                if (step_last) begin
                    if (bit_last) begin
                        bit_d = '0;
                        pix_d = last_pixel ? start_idx : (pix_q + stride);
                        if (last_pixel || stop_q || !regCtrlRun) begin
                            nxt_state = ST_LATCH;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            ST_LATCH: begin
                delay_d = delay_q + DELAY_BITS'(1);
                if (sync_of) begin
                    delay_d     = '0;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_BITS'(1);
                    stop_d      = 1'b0;
                    if (regCtrlLoop && regCtrlRun && !stop_q) begin
                        nxt_state = ST_TRANSMIT;
                        step_d    = '0;
                        bit_d     = '0;
                        pix_d     = start_idx;
                        bpp32_d   = regCtrlRgbw;
                    end else if (regCtrlRun) begin
                        nxt_state = ST_HALT;
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                if (!regCtrlRun) begin
                    nxt_state = ST_IDLE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase

        if (initSlow) begin
            step_d = '0;
            bit_d  = '0;
            pix_d  = '0;
        end

        // Init overrides everything except the frame counter.
        if (regCtrlInit) begin
            nxt_state   = ST_IDLE;
            step_d      = '0;
            bit_d       = '0;
            pix_d       = '0;
            stop_d      = 1'b0;
            delay_d     = '0;
            frame_cnt_d = frame_cnt_q;
        end
    end

    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            cur_state   <= ST_IDLE;
            step_q      <= '0;
            bit_q       <= '0;
            pix_q       <= '0;
            bpp32_q     <= 1'b0;
            stop_q      <= 1'b0;
            delay_q     <= '0;
            frame_cnt_q <= '0;
            slow_seen_q <= 1'b0;
            slow_done_q <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            step_q      <= step_d;
            bit_q       <= bit_d;
            pix_q       <= pix_d;
            bpp32_q     <= bpp32_d;
            stop_q      <= stop_d;
            delay_q     <= delay_d;
            frame_cnt_q <= frame_cnt_d;
            slow_seen_q <= initSlow;
            slow_done_q <= initSlow & ~slow_seen_q;
        end
    end

    assign initSlowDone    = slow_done_q;
    assign bitPatternIndex = step_q;
    assign pixelBitIndex   = bit_q;
    assign pixelIndex      = pix_q;
    assign state           = cur_state;
    assign streamOutput    = (cur_state == ST_TRANSMIT);
    assign streamReset     = (cur_state == ST_LATCH);
    assign streamBitOf     = bit_of;
    assign streamPixelOf   = bit_of && last_pixel;
    assign streamSyncOf    = sync_of;
    assign frameDone       = sync_of && !regCtrlInit;
    assign frameCount      = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_anton_neopixel_stream_sequencer.sv
// ============================================================================
// Module   : tb_anton_neopixel_stream_sequencer
// Purpose  : Randomised self-checking bench against a frame-level pixel model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_anton_neopixel_stream_sequencer;

    localparam int BE  = 15;
    localparam int RD  = 10;
    localparam int PS  = 8;
    localparam int FCB = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        regCtrlInit, regCtrlRun, regCtrlLoop, regCtrlLimit;
    logic        regCtrl32bit, regCtrlRgbw;
    logic [12:0] regMin, regMax;
    logic        initSlow;
    logic        initSlowDone;
    logic [2:0]  bitPatternIndex;
    logic [4:0]  pixelBitIndex;
    logic [3:0]  pixelIndex, pixelIndexMax;
    logic [1:0]  state;
    logic        streamOutput, streamReset, streamBitOf, streamPixelOf, streamSyncOf;
    logic        frameDone;
    logic [15:0] frameCount;

    int checks     = 0;
    int failures   = 0;
    int exp_frames = 0;
    int exp_pix[$];

    always #5 clk = ~clk;

    anton_neopixel_stream_sequencer #(
        .BUFFER_END(BE), .RESET_DELAY(RD), .PATTERN_STEPS(PS), .FRAME_CNT_BITS(FCB)
    ) dut (
        .clk6_4mhz(clk), .rstn(rstn),
        .regCtrlInit(regCtrlInit), .regCtrlRun(regCtrlRun), .regCtrlLoop(regCtrlLoop),
        .regCtrlLimit(regCtrlLimit), .regCtrl32bit(regCtrl32bit), .regCtrlRgbw(regCtrlRgbw),
        .regMin(regMin), .regMax(regMax),
        .initSlow(initSlow), .initSlowDone(initSlowDone),
        .bitPatternIndex(bitPatternIndex), .pixelBitIndex(pixelBitIndex),
        .pixelIndex(pixelIndex), .pixelIndexMax(pixelIndexMax), .state(state),
        .streamOutput(streamOutput), .streamReset(streamReset),
        .streamBitOf(streamBitOf), .streamPixelOf(streamPixelOf),
        .streamSyncOf(streamSyncOf), .frameDone(frameDone), .frameCount(frameCount)
    );

    // Pixel indices one frame should visit, from the current register settings.
    task automatic build_pixels();
        int mx, idx, eq;
        exp_pix.delete();
        mx  = regCtrlLimit ? int'(regMax[3:0]) : BE;
        idx = int'(regMin[3:0]);
        if (regCtrl32bit) idx = idx - (idx % 4);
        for (int n = 0; n < 64; n++) begin
            exp_pix.push_back(idx);
            eq = regCtrl32bit ? (idx - (idx % 4) + 3) : idx;
            if (eq >= mx) break;
            idx = (idx + (regCtrl32bit ? 4 : 1)) % 16;
        end
    endtask

    // Follows one frame cycle by cycle starting with the first TRANSMIT cycle.
    task automatic expect_frame(input string name, input int drop_cycle, input bit clear_loop);
        int   bpp, ppc, npix, c;
        logic e_bo, e_po, e_so;
        build_pixels();
        bpp  = regCtrlRgbw ? 32 : 24;
        ppc  = bpp * PS;
        npix = exp_pix.size();
        if (drop_cycle >= 0 && (drop_cycle / ppc) + 1 < npix) npix = (drop_cycle / ppc) + 1;
        for (int p = 0; p < npix; p++) begin
            for (int b = 0; b < bpp; b++) begin
                for (int s = 0; s < PS; s++) begin
                    @(negedge clk);
                    c    = (p * bpp + b) * PS + s;
                    e_bo = (s == PS - 1) && (b == bpp - 1);
                    e_po = e_bo && (p == exp_pix.size() - 1);
                    checks++;
                    if (state !== 2'd1 || pixelIndex !== 4'(exp_pix[p]) ||
                        pixelBitIndex !== 5'(b) || bitPatternIndex !== 3'(s) ||
                        streamBitOf !== e_bo || streamPixelOf !== e_po ||
                        streamOutput !== 1'b1 || streamReset !== 1'b0) begin
                        failures++;
                        $display("FAIL %s tx cycle %0d: got st=%0d idx=%0d bit=%0d step=%0d bitof=%b pixof=%b out=%b rst=%b, want st=1 idx=%0d bit=%0d step=%0d bitof=%b pixof=%b out=1 rst=0",
                                 name, c, state, pixelIndex, pixelBitIndex, bitPatternIndex,
                                 streamBitOf, streamPixelOf, streamOutput, streamReset,
                                 exp_pix[p], b, s, e_bo, e_po);
                    end
                    if (c == drop_cycle) regCtrlRun = 1'b0;
                    if (c == 0 && clear_loop) regCtrlLoop = 1'b0;
                end
            end
        end
        for (int l = 0; l <= RD; l++) begin
            @(negedge clk);
            e_so = (l == RD);
            checks++;
            if (state !== 2'd2 || streamReset !== 1'b1 || streamOutput !== 1'b0 ||
                streamSyncOf !== e_so || frameDone !== e_so || frameCount !== 16'(exp_frames)) begin
                failures++;
                $display("FAIL %s latch cycle %0d: got st=%0d rst=%b out=%b sync=%b done=%b fc=%0d, want st=2 rst=1 out=0 sync=%b done=%b fc=%0d",
                         name, l, state, streamReset, streamOutput, streamSyncOf, frameDone,
                         frameCount, e_so, e_so, exp_frames);
            end
        end
        exp_frames++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        regCtrlInit = 0; regCtrlRun = 0; regCtrlLoop = 0; regCtrlLimit = 0;
        regCtrl32bit = 0; regCtrlRgbw = 0; regMin = '0; regMax = '0; initSlow = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({state, streamOutput, streamReset, streamBitOf, streamPixelOf, streamSyncOf,
             frameDone, initSlowDone, pixelIndex, pixelBitIndex, bitPatternIndex} !== '0 ||
            frameCount !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs: got st=%0d idx=%0d bit=%0d step=%0d fc=%0d flags=%b%b%b%b%b%b%b, want all 0",
                     state, pixelIndex, pixelBitIndex, bitPatternIndex, frameCount, streamOutput,
                     streamReset, streamBitOf, streamPixelOf, streamSyncOf, frameDone, initSlowDone);
        end
        checks++;
        if (pixelIndexMax !== 4'd15) begin
            failures++;
            $display("FAIL reset_max_default: got %0d, want 15", pixelIndexMax);
        end
        regCtrlLimit = 1'b1; regMax = 13'h1FF6;
        #1;
        checks++;
        if (pixelIndexMax !== 4'd6) begin
            failures++;
            $display("FAIL reset_max_limit: got %0d, want 6", pixelIndexMax);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL reset_idle: got st=%0d, want 0", state);
        end
    endtask

    task automatic test_init_slow();
        int cnt = 0, first = -1;
        initSlow = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (initSlowDone === 1'b1) begin cnt++; if (first < 0) first = i; end
        end
        initSlow = 1'b0;
        for (int i = 5; i < 8; i++) begin
            @(negedge clk);
            if (initSlowDone === 1'b1) begin cnt++; if (first < 0) first = i; end
        end
        checks++;
        if (cnt != 1 || first != 0) begin
            failures++;
            $display("FAIL init_slow_held: got %0d pulses first at %0d, want 1 pulse at 0", cnt, first);
        end
        initSlow = 1'b1;
        @(negedge clk);
        checks++;
        if (initSlowDone !== 1'b1) begin
            failures++;
            $display("FAIL init_slow_rearm: got %b, want 1", initSlowDone);
        end
        initSlow = 1'b0;
        @(negedge clk);
        checks++;
        if (initSlowDone !== 1'b0) begin
            failures++;
            $display("FAIL init_slow_drop: got %b, want 0", initSlowDone);
        end
    endtask

    task automatic test_one_shot();
        regCtrlLimit = 1; regMax = 13'd3; regMin = 13'd0; regCtrl32bit = 0; regCtrlRgbw = 0;
        regCtrlLoop = 0; regCtrlRun = 1;
        expect_frame("oneshot", -1, 0);
        @(negedge clk);
        checks++;
        if (state !== 2'd3 || frameCount !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL oneshot_halt: got st=%0d fc=%0d, want st=3 fc=%0d", state, frameCount, exp_frames);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL oneshot_halt_hold: got st=%0d, want 3", state);
        end
        regCtrlRun = 0;
        @(negedge clk);
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL oneshot_idle: got st=%0d, want 0", state);
        end
    endtask

    task automatic test_loop();
        regCtrlLimit = 1; regMax = 13'd3; regMin = 13'd0; regCtrl32bit = 0; regCtrlRgbw = 0;
        regCtrlLoop = 1; regCtrlRun = 1;
        expect_frame("loop1", -1, 0);
        expect_frame("loop2", -1, 0);
        expect_frame("loop3", -1, 1);
        @(negedge clk);
        checks++;
        if (state !== 2'd3 || frameCount !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL loop_end: got st=%0d fc=%0d, want st=3 fc=%0d", state, frameCount, exp_frames);
        end
        regCtrlRun = 0;
        @(negedge clk);
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL loop_idle: got st=%0d, want 0", state);
        end
    endtask

    task automatic test_rgbw();
        regCtrlLimit = 0; regMax = 13'd0; regMin = 13'd5; regCtrl32bit = 1; regCtrlRgbw = 1;
        regCtrlLoop = 0; regCtrlRun = 1;
        #1;
        checks++;
        if (pixelIndexMax !== 4'd15) begin
            failures++;
            $display("FAIL rgbw_max: got %0d, want 15", pixelIndexMax);
        end
        expect_frame("rgbw", -1, 0);
        @(negedge clk);
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL rgbw_halt: got st=%0d, want 3", state);
        end
        regCtrlRun = 0;
        @(negedge clk);
    endtask

    task automatic test_stop();
        regCtrlLimit = 1; regMax = 13'd3; regMin = 13'd0; regCtrl32bit = 0; regCtrlRgbw = 0;
        regCtrlLoop = 1; regCtrlRun = 1;
        expect_frame("stop", (1 * 24 + 10) * PS, 0);
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || frameCount !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL stop_idle: got st=%0d fc=%0d, want st=0 fc=%0d", state, frameCount, exp_frames);
        end
        regCtrlLoop = 0;
    endtask

    task automatic test_single_pixel();
        regCtrlLimit = 1; regMax = 13'd2; regMin = 13'd3; regCtrl32bit = 0; regCtrlRgbw = 0;
        regCtrlLoop = 0; regCtrlRun = 1;
        expect_frame("single", -1, 0);
        @(negedge clk);
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL single_halt: got st=%0d, want 3", state);
        end
        regCtrlRun = 0;
        @(negedge clk);
    endtask

    task automatic test_init_latch();
        regCtrlLimit = 1; regMax = 13'd0; regMin = 13'd0; regCtrl32bit = 0; regCtrlRgbw = 0;
        regCtrlLoop = 0; regCtrlRun = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (state === 2'd2) break;
        end
        checks++;
        if (state !== 2'd2) begin
            failures++;
            $display("FAIL init_latch_wait: got st=%0d, want 2 within 1000 cycles", state);
        end
        repeat (4) @(negedge clk);
        regCtrlInit = 1;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || pixelIndex !== 4'd0 || streamReset !== 1'b0 ||
            frameCount !== 16'(exp_frames)) begin
            failures++;
            $display("FAIL init_latch: got st=%0d idx=%0d rst=%b fc=%0d, want st=0 idx=0 rst=0 fc=%0d",
                     state, pixelIndex, streamReset, frameCount, exp_frames);
        end
        regCtrlInit = 0;
        expect_frame("after_init", -1, 0);
        @(negedge clk);
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL after_init_halt: got st=%0d, want 3", state);
        end
        regCtrlRun = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            regCtrlLimit = 1'($urandom_range(0, 1));
            regMax       = 13'($urandom_range(0, 7)) | 13'($urandom_range(0, 511) << 4);
            regMin       = 13'($urandom_range(0, 8191));
            regCtrl32bit = 1'($urandom_range(0, 1));
            regCtrlRgbw  = 1'($urandom_range(0, 1));
            regCtrlLoop  = 0;
            regCtrlRun   = 1;
            #1;
            checks++;
            if (pixelIndexMax !== (regCtrlLimit ? regMax[3:0] : 4'd15)) begin
                failures++;
                $display("FAIL rand%0d_max: got %0d, want %0d", k, pixelIndexMax,
                         regCtrlLimit ? regMax[3:0] : 4'd15);
            end
            expect_frame($sformatf("rand%0d", k), -1, 0);
            @(negedge clk);
            checks++;
            if (state !== 2'd3 || frameCount !== 16'(exp_frames)) begin
                failures++;
                $display("FAIL rand%0d_halt: got st=%0d fc=%0d, want st=3 fc=%0d", k, state, frameCount, exp_frames);
            end
            regCtrlRun = 0;
            @(negedge clk);
            checks++;
            if (state !== 2'd0) begin
                failures++;
                $display("FAIL rand%0d_idle: got st=%0d, want 0", k, state);
            end
        end
    endtask

    task automatic test_async_reset();
        regCtrlLimit = 0; regMin = 13'd0; regCtrl32bit = 0; regCtrlRgbw = 0; regCtrlRun = 1;
        repeat (50) @(negedge clk);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL areset_pre: got st=%0d, want 1", state);
        end
        #2 rstn = 1'b0;
        #1;
        exp_frames = 0;
        checks++;
        if ({state, streamOutput, streamReset, streamBitOf, streamPixelOf, streamSyncOf,
             frameDone, initSlowDone, pixelIndex, pixelBitIndex, bitPatternIndex} !== '0 ||
            frameCount !== 16'd0) begin
            failures++;
            $display("FAIL areset_outputs: got st=%0d idx=%0d bit=%0d step=%0d fc=%0d out=%b, want all 0",
                     state, pixelIndex, pixelBitIndex, bitPatternIndex, frameCount, streamOutput);
        end
        @(negedge clk);
        regCtrlRun = 0;
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || frameCount !== 16'd0) begin
            failures++;
            $display("FAIL areset_post: got st=%0d fc=%0d, want st=0 fc=0", state, frameCount);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_slow();
        test_one_shot();
        test_loop();
        test_rgbw();
        test_stop();
        test_single_pixel();
        test_init_latch();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
